// File: rtl/noc_pkg.sv
// Shared NoC router definitions: crossbar select codes, source indices and
// the round-robin successor helper.
package noc_pkg;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned SRC_W = 2;

  typedef struct packed {
    logic ni_out;
    logic vc;
    logic up;
  } sel_t;

  localparam logic [SEL_W-1:0] SEL_IDLE     = 3'b000;
  localparam logic [SEL_W-1:0] SEL_NI_DOWN  = 3'b010;
  localparam logic [SEL_W-1:0] SEL_VC1_DOWN = 3'b011;
  localparam logic [SEL_W-1:0] SEL_VC0_NI   = 3'b100;

  localparam logic [SRC_W-1:0] SRC_NI  = 2'd0;
  localparam logic [SRC_W-1:0] SRC_VC1 = 2'd1;
  localparam logic [SRC_W-1:0] SRC_VC0 = 2'd2;

  // Next source in the 0 -> 1 -> 2 -> 0 scan order; the unused code 3 maps to 0.
  function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] s);
    logic [SRC_W-1:0] n;
    case (s)
      SRC_NI:  n = SRC_VC1;
      SRC_VC1: n = SRC_VC0;
      default: n = SRC_NI;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin pick: scans from ptr_i and returns a one-hot
// winner among the eligible sources.
module rr_arb3
  import noc_pkg::*;
(
  input  logic [2:0]       elig_i,
  input  logic [SRC_W-1:0] ptr_i,
  output logic [2:0]       gnt_o
);

  logic [SRC_W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    idx   = (ptr_i == 2'd3) ? SRC_NI : ptr_i;
    for (int k = 0; k < 3; k++) begin
      if (gnt_o == 3'b000 && elig_i[idx]) begin
        gnt_o[idx] = 1'b1;
      end
      idx = next_src(idx);
    end
  end

endmodule

// File: rtl/switch_alloc.sv
// Per-port switch allocator: round-robin choice among NI injection, VC1
// forwarding and VC0 ejection with wormhole locking and down-link credits.
module switch_alloc
  import noc_pkg::*;
#(
  parameter int unsigned CREDITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ni_req,
  input  logic ni_tail,
  input  logic vc1_req,
  input  logic vc1_tail,
  input  logic vc0_req,
  input  logic ni_ready,
  input  logic credit_in,
  output logic sel_NI_out,
  output logic sel_vc,
  output logic sel_up,
  output logic gnt_ni,
  output logic gnt_vc1,
  output logic gnt_vc0,
  output logic credit_ovf
);

  localparam int unsigned CW = $clog2(CREDITS + 1);

  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             lock_v_q, lock_v_d;
  logic             lock_own_q, lock_own_d;
  logic [CW-1:0]    cred_q, cred_d;
  logic             ovf_q, ovf_d;

  logic [2:0]       elig;
  logic [2:0]       win;
  logic [SRC_W-1:0] win_idx;
  logic             cred_ok;
  logic             cred_full;
  logic             down_gnt;
  logic             down_tail;
  sel_t             sel;

  assign cred_ok   = (cred_q != '0);
  assign cred_full = (cred_q == CW'(CREDITS));

  // A locked down link admits only its owner; ejection ignores the lock.
  assign elig[SRC_NI]  = ni_req  & cred_ok & (~lock_v_q | ~lock_own_q);
  assign elig[SRC_VC1] = vc1_req & cred_ok & (~lock_v_q |  lock_own_q);
  assign elig[SRC_VC0] = vc0_req & ni_ready;

  rr_arb3 u_arb (
    .elig_i (elig),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (win)
  );

  assign down_gnt  = win[SRC_NI] | win[SRC_VC1];
  assign down_tail = win[SRC_NI] ? ni_tail : vc1_tail;
  assign win_idx   = win[SRC_VC1] ? SRC_VC1 : (win[SRC_VC0] ? SRC_VC0 : SRC_NI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= SRC_NI;
      lock_v_q   <= 1'b0;
      lock_own_q <= 1'b0;
      cred_q     <= CW'(CREDITS);
      ovf_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_v_q   <= lock_v_d;
      lock_own_q <= lock_own_d;
      cred_q     <= cred_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_v_d   = lock_v_q;
    lock_own_d = lock_own_q;
    cred_d     = cred_q;
    ovf_d      = ovf_q;

    if (win != 3'b000) begin
      rr_ptr_d = next_src(win_idx);
    end

    if (down_gnt) begin
      if (down_tail) begin
        lock_v_d = 1'b0;
      end else begin
        lock_v_d   = 1'b1;
        lock_own_d = win[SRC_VC1];
      end
    end

    // A grant and a returned credit in the same cycle cancel out.
    case ({down_gnt, credit_in})
      2'b10: cred_d = cred_q - CW'(1);
      2'b01: begin
        if (cred_full) begin
          ovf_d = 1'b1;
        end else begin
          cred_d = cred_q + CW'(1);
        end
      end
      default: cred_d = cred_q;
    endcase
  end

  always_comb begin
    sel     = sel_t'(SEL_IDLE);
    gnt_ni  = 1'b0;
    gnt_vc1 = 1'b0;
    gnt_vc0 = 1'b0;
    if (!rst) begin
      gnt_ni  = win[SRC_NI];
      gnt_vc1 = win[SRC_VC1];
      gnt_vc0 = win[SRC_VC0];
      if (win[SRC_NI]) begin
        sel = sel_t'(SEL_NI_DOWN);
      end else if (win[SRC_VC1]) begin
        sel = sel_t'(SEL_VC1_DOWN);
      end else if (win[SRC_VC0]) begin
        sel = sel_t'(SEL_VC0_NI);
      end
    end
  end

  assign sel_NI_out = sel.ni_out;
  assign sel_vc     = sel.vc;
  assign sel_up     = sel.up;
  assign credit_ovf = ovf_q;

endmodule

// File: tb/tb_switch_alloc.sv
// Directed bench for switch_alloc with a per-cycle behavioural model and
// literal expectations on every stimulus step.
module tb_switch_alloc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ni_req = 1'b0, ni_tail = 1'b0, vc1_req = 1'b0, vc1_tail = 1'b0;
  logic vc0_req = 1'b0, ni_ready = 1'b0, credit_in = 1'b0;
  logic sel_NI_out, sel_vc, sel_up, gnt_ni, gnt_vc1, gnt_vc0, credit_ovf;

  int errors = 0;
  int checks = 0;

  // Model state: lock owner -1 means the down link is free.
  int m_ptr = 0, m_lock = -1, m_cred = 4, m_ovf = 0;
  int n_ptr = 0, n_lock = -1, n_cred = 4, n_ovf = 0;

  switch_alloc #(.CREDITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ni_req     (ni_req),
    .ni_tail    (ni_tail),
    .vc1_req    (vc1_req),
    .vc1_tail   (vc1_tail),
    .vc0_req    (vc0_req),
    .ni_ready   (ni_ready),
    .credit_in  (credit_in),
    .sel_NI_out (sel_NI_out),
    .sel_vc     (sel_vc),
    .sel_up     (sel_up),
    .gnt_ni     (gnt_ni),
    .gnt_vc1    (gnt_vc1),
    .gnt_vc0    (gnt_vc0),
    .credit_ovf (credit_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr = 0; m_lock = -1; m_cred = 4; m_ovf = 0;
    end else begin
      m_ptr = n_ptr; m_lock = n_lock; m_cred = n_cred; m_ovf = n_ovf;
    end
  end

  // Per-cycle model: outputs from current requests, next state for the edge.
  always @(negedge clk) begin
    bit e[3];
    int win, s, exp_code, exp_gnt;
    bit down, tail;
    win = -1;
    n_ptr = m_ptr; n_lock = m_lock; n_cred = m_cred; n_ovf = m_ovf;
    e[0] = ni_req && m_cred > 0 && (m_lock != 1);
    e[1] = vc1_req && m_cred > 0 && (m_lock != 0);
    e[2] = vc0_req && ni_ready;
    for (int k = 0; k < 3; k++) begin
      s = (m_ptr + k) % 3;
      if (win < 0 && e[s]) win = s;
    end
    exp_code = (win == 0) ? 2 : (win == 1) ? 3 : (win == 2) ? 4 : 0;
    exp_gnt  = (win < 0) ? 0 : (1 << win);
    if (rst) begin
      exp_code = 0;
      exp_gnt  = 0;
    end
    check("model_code", 32'({sel_NI_out, sel_vc, sel_up}), 32'(exp_code));
    check("model_gnt", 32'({gnt_vc0, gnt_vc1, gnt_ni}), 32'(exp_gnt));
    check("model_ovf", 32'(credit_ovf), 32'(rst ? 0 : m_ovf));
    down = (win == 0 || win == 1);
    tail = (win == 0) ? ni_tail : vc1_tail;
    if (win >= 0) n_ptr = (win + 1) % 3;
    if (down) n_lock = tail ? -1 : win;
    if (down && !credit_in) n_cred = m_cred - 1;
    else if (!down && credit_in) begin
      if (m_cred == 4) n_ovf = 1;
      else n_cred = m_cred + 1;
    end
  end

  // Drive one cycle of inputs after the edge, then check the literal code.
  task automatic step(input bit nr, input bit nt, input bit vr, input bit vt,
                      input bit er, input bit rd, input bit cr,
                      input logic [2:0] exp_code, input string name);
    @(posedge clk);
    #1;
    ni_req = nr; ni_tail = nt; vc1_req = vr; vc1_tail = vt;
    vc0_req = er; ni_ready = rd; credit_in = cr;
    @(negedge clk);
    check(name, 32'({sel_NI_out, sel_vc, sel_up}), 32'(exp_code));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with requests active: outputs must stay at zero.
    ni_req = 1'b1; ni_tail = 1'b1; vc0_req = 1'b1; ni_ready = 1'b1; vc1_req = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_code", 32'({sel_NI_out, sel_vc, sel_up}), 32'd0);
      check("rst_gnt", 32'({gnt_vc0, gnt_vc1, gnt_ni}), 32'd0);
    end
    @(posedge clk);
    #1;
    ni_req = 1'b0; ni_tail = 1'b0; vc0_req = 1'b0; ni_ready = 1'b0; vc1_req = 1'b0;
    rst = 1'b0;

    // Single-flit NI injection.
    step(1, 1, 0, 0, 0, 0, 0, 3'b010, "ni_single");
    check("ni_single_gnt", 32'(gnt_ni), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1, 3'b000, "cred_return");
    check("cred_after_one", 32'(dut.cred_q), 32'd3);
    check("ptr_after_one", 32'(dut.rr_ptr_q), 32'd1);

    // Alternating single-flit traffic until credits run out.
    step(1, 1, 1, 1, 0, 0, 0, 3'b011, "alt0");
    step(1, 1, 1, 1, 0, 0, 0, 3'b010, "alt1");
    step(1, 1, 1, 1, 0, 0, 0, 3'b011, "alt2");
    step(1, 1, 1, 1, 0, 0, 0, 3'b010, "alt3");
    step(1, 1, 1, 1, 0, 0, 0, 3'b000, "cred_empty");
    step(1, 1, 1, 1, 0, 0, 1, 3'b000, "cred_empty_ret");
    step(1, 1, 1, 1, 0, 0, 0, 3'b011, "one_credit");
    step(1, 1, 1, 1, 0, 0, 0, 3'b000, "cred_empty2");
    check("cred_zero", 32'(dut.cred_q), 32'd0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 1, 3'b000, "refill_a");

    // NI three-flit packet holds the down link against VC1.
    step(1, 0, 1, 1, 0, 0, 1, 3'b010, "pkt_head");
    step(1, 0, 1, 1, 0, 0, 1, 3'b010, "pkt_body");
    step(1, 1, 1, 1, 0, 0, 1, 3'b010, "pkt_tail");
    step(0, 0, 1, 1, 0, 0, 1, 3'b011, "pkt_vc1_after");
    check("cred_balanced", 32'(dut.cred_q), 32'd4);

    // Ejection interleaves with a locked NI packet.
    step(1, 0, 1, 1, 1, 1, 0, 3'b100, "il_ej0");
    step(1, 0, 1, 1, 1, 1, 0, 3'b010, "il_head");
    step(1, 0, 1, 1, 1, 1, 0, 3'b100, "il_ej1");
    step(1, 0, 1, 1, 1, 1, 0, 3'b010, "il_body");
    step(1, 0, 1, 1, 1, 1, 0, 3'b100, "il_ej2");
    check("lock_held", 32'(dut.lock_v_q), 32'd1);
    step(0, 0, 1, 1, 0, 0, 0, 3'b000, "il_owner_idle");
    step(1, 1, 1, 1, 0, 0, 0, 3'b010, "il_tail");
    step(0, 0, 1, 1, 0, 0, 0, 3'b011, "il_vc1");
    check("lock_free", 32'(dut.lock_v_q), 32'd0);
    step(0, 0, 1, 1, 0, 0, 0, 3'b000, "il_no_cred");
    repeat (4) step(0, 0, 0, 0, 0, 0, 1, 3'b000, "refill_b");

    // Ejection gated by ni_ready, granted in the same cycle it rises.
    step(0, 0, 0, 0, 1, 0, 0, 3'b000, "ej_blocked");
    check("ej_blocked_gnt", 32'(gnt_vc0), 32'd0);
    step(0, 0, 0, 0, 1, 1, 0, 3'b100, "ej_ready");
    check("ej_ready_gnt", 32'(gnt_vc0), 32'd1);

    // Credit overflow is sticky.
    step(0, 0, 0, 0, 0, 0, 1, 3'b000, "ovf_pulse");
    check("ovf_before_edge", 32'(credit_ovf), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 3'b000, "ovf_after");
    check("ovf_set", 32'(credit_ovf), 32'd1);
    check("cred_saturated", 32'(dut.cred_q), 32'd4);
    step(0, 0, 0, 0, 0, 0, 0, 3'b000, "ovf_hold");
    check("ovf_sticky", 32'(credit_ovf), 32'd1);

    // Asynchronous reset in the middle of a locked packet.
    step(1, 0, 0, 0, 0, 0, 0, 3'b010, "rst_pkt_head");
    step(1, 0, 0, 0, 0, 0, 0, 3'b010, "rst_pkt_body");
    #2;
    rst = 1'b1;
    ni_req = 1'b0; ni_tail = 1'b0;
    #1;
    check("async_cred", 32'(dut.cred_q), 32'd4);
    check("async_lock", 32'(dut.lock_v_q), 32'd0);
    check("async_ovf", 32'(credit_ovf), 32'd0);
    check("async_code", 32'({sel_NI_out, sel_vc, sel_up}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 0, 1, 1, 0, 0, 0, 3'b011, "post_rst_vc1");
    step(1, 1, 1, 1, 0, 0, 0, 3'b010, "post_rst_ni");
    step(0, 0, 0, 0, 0, 0, 0, 3'b000, "final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
